// File: rtl/tick_timer_bank.sv
// tick_timer_bank
//   A bank of NUM_CH independent programmable tick timers, used for frame
//   pacing, pulse stretching and debounce timing. Each channel has:
//     - a runtime period,
//     - a periodic or one-shot mode,
//     - a pause enable,
//   and emits a 1-cycle done strobe at terminal count.
//
//   Optional feature, selected with the macro TIMER_BANK_IRQ_EN:
//   sticky per-channel done flags plus a combined irq output.
//
// Parameters
//   NUM_CH  number of channels (1..8)
//   CNT_W   counter/period width per channel
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   enable     per-channel run enable (0 = pause, count frozen)
//   oneshot    per-channel mode (1 = one-shot, 0 = periodic)
//   start      per-channel start/retrigger pulse
//   period     flat period vector, ch i = [i*CNT_W +: CNT_W]
//   done       1-cycle terminal-count strobe
//   busy       periodic: enable; one-shot: channel in RUN
//   count      flat current count, same packing as period
//   irq_clear  (TIMER_BANK_IRQ_EN) clear sticky flag
//   irq_flags  (TIMER_BANK_IRQ_EN) sticky done flags
//   irq        (TIMER_BANK_IRQ_EN) registered OR of irq_flags
module tick_timer_bank #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 26
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH-1:0]       oneshot,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH*CNT_W-1:0] period,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH*CNT_W-1:0] count
`ifdef TIMER_BANK_IRQ_EN
   ,
   input  logic [NUM_CH-1:0]       irq_clear,
   output logic [NUM_CH-1:0]       irq_flags,
   output logic                    irq
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] plen_q, plen_d;
      logic [CNT_W-1:0] p_last;
      logic [CNT_W-1:0] p_in;
      logic             done_q, done_d;
      logic             active;

      assign p_in   = period[i*CNT_W +: CNT_W];
      // A latched period of 0 behaves as 1: terminal count every tick.
      assign p_last = (plen_q == '0) ? '0 : plen_q - ONE;
      // Periodic channels run regardless of state; one-shot needs RUN.
      assign active = (st_q == RUN) || !oneshot[i];

      always_comb begin
         st_d   = st_q;
         cnt_d  = cnt_q;
         plen_d = plen_q;
         done_d = 1'b0;
         if (start[i]) begin
            // Start/retrigger wins over terminal count and arms even while paused.
            st_d   = RUN;
            cnt_d  = '0;
            plen_d = p_in;
         end else if (enable[i] && active) begin
            if (cnt_q == p_last) begin
               cnt_d  = '0;
               done_d = 1'b1;
               plen_d = p_in;
               // Mode is sampled here, so a mode change lands at terminal count.
               st_d   = oneshot[i] ? IDLE : RUN;
            end else begin
               cnt_d = cnt_q + ONE;
               st_d  = RUN;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            plen_q <= p_in;
            done_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            plen_q <= plen_d;
            done_q <= done_d;
         end
      end

      assign done[i]                  = done_q;
      assign count[i*CNT_W +: CNT_W]  = cnt_q;
      // Masked during reset so every output reads 0 while reset is held.
      assign busy[i] = !reset && (oneshot[i] ? (st_q == RUN) : enable[i]);
   end

`ifdef TIMER_BANK_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_flags <= '0;
         irq       <= 1'b0;
      end else begin
         // Set wins over a same-cycle clear.
         irq_flags <= done | (irq_flags & ~irq_clear);
         irq       <= |irq_flags;
      end
   end
`endif

endmodule

// File: tb/tb_tick_timer_bank.sv
// tb_tick_timer_bank
//   Scoreboard bench for tick_timer_bank.
//   A stimulus process drives the inputs on the falling edge and pushes the
//   expected post-edge outputs, produced by a reference model, into a queue.
//   A monitor process pops that queue after each rising edge and compares.
//
//   The reference model tracks "ticks left until done" per channel instead
//   of a count register; the visible count is derived from it.
//   The irq checks are active only when TIMER_BANK_IRQ_EN is defined.
module tb_tick_timer_bank;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 26;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_CH-1:0]       enable, oneshot, start;
   logic [NUM_CH*CNT_W-1:0] period;
   logic [NUM_CH-1:0]       done, busy;
   logic [NUM_CH*CNT_W-1:0] count;
`ifdef TIMER_BANK_IRQ_EN
   logic [NUM_CH-1:0]       irq_clear, irq_flags;
   logic                    irq;
`endif

   tick_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot),
      .start(start), .period(period), .done(done), .busy(busy), .count(count)
`ifdef TIMER_BANK_IRQ_EN
      , .irq_clear(irq_clear), .irq_flags(irq_flags), .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_CH-1:0]       done;
      logic [NUM_CH-1:0]       busy;
      logic [NUM_CH*CNT_W-1:0] count;
      logic [NUM_CH-1:0]       flags;
      logic                    irq;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model state.
   int plen[NUM_CH];
   int left[NUM_CH];
   bit run[NUM_CH];
   bit m_done[NUM_CH];
   bit m_flag[NUM_CH];
   bit m_irq;

   function automatic int eff(input int p);
      return (p == 0) ? 1 : p;
   endfunction

   // Apply the current inputs for one edge.
   // Advance the model and queue the expected outputs.
   task automatic tick();
      exp_t e;
      bit   any_flag;
      any_flag = 1'b0;
      for (int i = 0; i < NUM_CH; i++) any_flag |= m_flag[i];
      e.done = '0; e.busy = '0; e.count = '0; e.flags = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         int pin;
         bit clr;
         pin = int'(period[i*CNT_W +: CNT_W]);
         clr = 1'b0;
`ifdef TIMER_BANK_IRQ_EN
         clr = irq_clear[i];
`endif
         m_flag[i] = reset ? 1'b0 : (m_done[i] | (m_flag[i] & ~clr));
         m_done[i] = 1'b0;
         if (reset) begin
            plen[i] = pin; left[i] = eff(pin); run[i] = 1'b0;
         end else if (start[i]) begin
            plen[i] = pin; left[i] = eff(pin); run[i] = 1'b1;
         end else if (enable[i] && (run[i] || !oneshot[i])) begin
            left[i]--;
            run[i] = 1'b1;
            if (left[i] == 0) begin
               m_done[i] = 1'b1;
               plen[i]   = pin;
               left[i]   = eff(pin);
               run[i]    = !oneshot[i];
            end
         end
         e.done[i]                 = m_done[i];
         e.count[i*CNT_W +: CNT_W] = CNT_W'(eff(plen[i]) - left[i]);
         e.busy[i]                 = !reset && (oneshot[i] ? run[i] : enable[i]);
         e.flags[i]                = m_flag[i];
      end
      m_irq = reset ? 1'b0 : any_flag;
      e.irq = m_irq;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic set_per(input int ch, input int p);
      period[ch*CNT_W +: CNT_W] = CNT_W'(p);
   endtask

   // Monitor: compare every rising edge that has an expectation queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (done !== e.done) begin
               n_bad++;
               $display("FAIL done t=%0t got=%b exp=%b", $time, done, e.done);
            end
            if (busy !== e.busy) begin
               n_bad++;
               $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
            end
            if (count !== e.count) begin
               n_bad++;
               $display("FAIL count t=%0t got=%h exp=%h", $time, count, e.count);
            end
`ifdef TIMER_BANK_IRQ_EN
            if (irq_flags !== e.flags || irq !== e.irq) begin
               n_bad++;
               $display("FAIL irq t=%0t got=%b/%b exp=%b/%b", $time,
                        irq_flags, irq, e.flags, e.irq);
            end
`endif
         end
      end
   end

   initial begin
      reset = 1'b1; enable = '0; oneshot = '0; start = '0; period = '0;
`ifdef TIMER_BANK_IRQ_EN
      irq_clear = '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         plen[i] = 0; left[i] = 1; run[i] = 0; m_done[i] = 0; m_flag[i] = 0;
      end
      m_irq = 0;
      @(negedge clk);
      repeat (3) tick();
      reset = 1'b0;

      // ch0 periodic, period 5: done every 5 edges.
      set_per(0, 5); enable[0] = 1'b1;
      repeat (16) tick();
      enable[0] = 1'b0;
      tick();

      // ch1 one-shot, period 3: single start pulse.
      oneshot[1] = 1'b1; set_per(1, 3); start[1] = 1'b1;
      tick();
      start[1] = 1'b0; enable[1] = 1'b1;
      repeat (8) tick();

      // ch0 period 4: pause for 7 cycles at count 2, then resume.
      reset = 1'b1; set_per(0, 4);
      tick();
      reset = 1'b0; enable[0] = 1'b1;
      repeat (2) tick();
      enable[0] = 1'b0;
      repeat (7) tick();
      enable[0] = 1'b1;
      repeat (6) tick();

      // ch0 period 10 -> 3 mid-period, then period 0.
      reset = 1'b1; set_per(0, 10);
      tick();
      reset = 1'b0;
      repeat (4) tick();
      set_per(0, 3);
      repeat (12) tick();
      set_per(0, 0);
      repeat (5) tick();

      // ch1 one-shot period 6: retrigger at count 5, then reset mid-count.
      set_per(1, 6); start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      repeat (5) tick();
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();

`ifdef TIMER_BANK_IRQ_EN
      // irq: clear colliding with a fresh done keeps the flag set.
      enable = '0; oneshot = '0; set_per(0, 2); start[0] = 1'b1;
      tick();
      start[0] = 1'b0; enable[0] = 1'b1;
      repeat (4) tick();
      irq_clear[0] = 1'b1;
      repeat (3) tick();
      enable[0] = 1'b0;
      tick();
      irq_clear[0] = 1'b0;
      repeat (2) tick();
`endif

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NUM_CH; i++) begin
            enable[i] = ($urandom_range(0, 7) != 0);
            start[i]  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) oneshot[i] = ~oneshot[i];
            if ($urandom_range(0, 7) == 0) set_per(i, $urandom_range(0, 9));
`ifdef TIMER_BANK_IRQ_EN
            irq_clear[i] = ($urandom_range(0, 5) == 0);
`endif
         end
         tick();
      end

      reset = 1'b0; enable = '0; start = '0;
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
